apb_timer_irq_ctrl: RTL and testbench

APB-mapped interrupt capture stage placed directly downstream of the APB timer. It converts the timer's single-cycle `irq_o[1:0]` event pulses (overflow, compare match) into sticky, maskable pending bits. It counts events lost while a source was already pending and drives one level-sensitive interrupt line to the core's event unit. The block shares the timer's clock and APB segment.

---
 rtl/apb_timer_irq_ctrl.sv | 59 +++++
 tb/tb_apb_timer_irq_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_irq_ctrl.sv
// apb_timer_irq_ctrl: turns timer event pulses into sticky maskable pending bits,
// counts events lost while already pending, and drives one level interrupt.
module apb_timer_irq_ctrl #(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int N_SRC = 2
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic [APB_ADDR_WIDTH-1:0] PADDR,
   input  logic [31:0]               PWDATA,
   input  logic                      PWRITE,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   output logic [31:0]               PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR,
   input  logic [N_SRC-1:0]          irq_i,
   output logic                      irq_o
);
   logic [N_SRC-1:0] pending, mask, irq_prev, evt, clr;
   logic [7:0] miss [N_SRC];
   logic [31:0] miss_word;
   logic [1:0] idx;
   logic wr, rd, wr_miss, unused_ok;
   assign idx = PADDR[3:2];
   assign wr = PSEL & PENABLE & PWRITE;
   assign rd = PSEL & PENABLE & ~PWRITE;
   assign wr_miss = wr & (idx == 2'd3);
   assign clr = (wr && idx == 2'd1) ? PWDATA[N_SRC-1:0] : '0;
   assign evt = irq_i & ~irq_prev;
   assign irq_o = |(pending & mask);
   assign PREADY = 1'b1;
   assign PSLVERR = 1'b0;
   assign unused_ok = ^{PADDR, PWDATA};
   always_comb begin
      miss_word = '0;
      for (int i = 0; i < N_SRC; i++) miss_word[8*i +: 8] = miss[i];
   end
   assign PRDATA = !rd          ? 32'd0 :
                   idx == 2'd0  ? 32'(pending) :
                   idx == 2'd2  ? 32'(mask) :
                   idx == 2'd3  ? miss_word : 32'd0;
   // a new event beats a same-cycle CLEAR; a MISS write beats a same-cycle increment
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         pending  <= '0;
         mask     <= '0;
         irq_prev <= '0;
         for (int i = 0; i < N_SRC; i++) miss[i] <= '0;
      end else begin
         irq_prev <= irq_i;
         pending  <= evt | (pending & ~clr);
         if (wr && idx == 2'd2) mask <= PWDATA[N_SRC-1:0];
         for (int i = 0; i < N_SRC; i++)
            if (wr_miss) miss[i] <= '0;
            else if (evt[i] && pending[i] && !clr[i] && miss[i] != 8'hff) miss[i] <= miss[i] + 8'd1;
      end
   end
endmodule

// File: tb/tb_apb_timer_irq_ctrl.sv
// tb_apb_timer_irq_ctrl: directed vector table, corner sequences and random traffic
// checked against an event-level reference model of the capture stage.
module tb_apb_timer_irq_ctrl;
   logic HCLK = 1'b0, HRESETn = 1'b0;
   logic [11:0] PADDR = '0;
   logic [31:0] PWDATA = '0, PRDATA;
   logic PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0, PREADY, PSLVERR, irq_o;
   logic [1:0] irq_i = '0;
   int vectors = 0, miscompares = 0;

   always #5 HCLK = ~HCLK;

   apb_timer_irq_ctrl #(.APB_ADDR_WIDTH(12), .N_SRC(2)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
      .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .irq_i(irq_i), .irq_o(irq_o));

   // reference model: per-source pending flag, lost-event count, enable and last input level
   bit m_pend [2];
   bit m_mask [2];
   bit m_prev [2];
   int m_miss [2];

   function automatic logic m_irq();
      return (m_pend[0] && m_mask[0]) || (m_pend[1] && m_mask[1]);
   endfunction

   function automatic logic [31:0] m_rd(input logic [1:0] a);
      case (a)
         2'd0: return {30'd0, m_pend[1], m_pend[0]};
         2'd2: return {30'd0, m_mask[1], m_mask[0]};
         2'd3: return 32'(m_miss[1] * 256 + m_miss[0]);
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_edge();
      bit wr;
      int a;
      wr = PSEL && PENABLE && PWRITE;
      a = int'(PADDR[3:2]);
      if (!HRESETn) begin
         for (int n = 0; n < 2; n++) begin
            m_pend[n] = 0; m_mask[n] = 0; m_prev[n] = 0; m_miss[n] = 0;
         end
         return;
      end
      for (int n = 0; n < 2; n++) begin
         bit e, c;
         e = irq_i[n] && !m_prev[n];
         c = wr && a == 1 && PWDATA[n];
         if (e && m_pend[n] && !c && m_miss[n] < 255) m_miss[n] = m_miss[n] + 1;
         if (wr && a == 3) m_miss[n] = 0;
         if (e) m_pend[n] = 1;
         else if (c) m_pend[n] = 0;
         if (wr && a == 2) m_mask[n] = PWDATA[n];
         m_prev[n] = irq_i[n];
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst_n, input logic [1:0] irq, input int op,
                        input logic [11:0] addr, input logic [31:0] wd);
      @(negedge HCLK);
      HRESETn = rst_n;
      irq_i = irq;
      PSEL = op != 0;
      PENABLE = op != 0;
      PWRITE = op == 1;
      PADDR = addr;
      PWDATA = wd;
      #1;
   endtask

   task automatic edge_();
      model_edge();
      @(posedge HCLK);
   endtask

   function automatic logic [11:0] ad(input logic [1:0] a);
      return {8'h5A, a, 2'b11};
   endfunction

   // one cycle checked against the model: op 0 idle, 1 write, 2 read
   task automatic cycle(input logic [1:0] irq, input int op, input logic [1:0] a, input logic [31:0] wd);
      drive(1'b1, irq, op, ad(a), wd);
      chk("model irq_o", {31'd0, irq_o}, {31'd0, m_irq()});
      chk("model prdata", PRDATA, op == 2 ? m_rd(a) : 32'd0);
      edge_();
   endtask

   task automatic rd_exp(input string name, input logic [1:0] irq, input logic [1:0] a, input logic [31:0] exp);
      drive(1'b1, irq, 2, ad(a), 32'd0);
      chk(name, PRDATA, exp);
      chk({name, " model"}, PRDATA, m_rd(a));
      edge_();
   endtask

   typedef struct {
      logic [1:0]  irq;
      int          op;
      logic [1:0]  a;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        io;
   } vec_t;
   vec_t tbl [25];

   initial begin
      tbl[0]  = '{2'b00, 2, 2'd0, 32'd0, 32'd0, 1'b0};
      tbl[1]  = '{2'b00, 2, 2'd2, 32'd0, 32'd0, 1'b0};
      tbl[2]  = '{2'b00, 2, 2'd3, 32'd0, 32'd0, 1'b0};
      tbl[3]  = '{2'b01, 0, 2'd0, 32'd0, 32'd0, 1'b0};
      tbl[4]  = '{2'b00, 2, 2'd0, 32'd0, 32'd1, 1'b0};
      tbl[5]  = '{2'b00, 1, 2'd2, 32'd3, 32'd0, 1'b0};
      tbl[6]  = '{2'b00, 2, 2'd2, 32'd0, 32'd3, 1'b1};
      tbl[7]  = '{2'b00, 1, 2'd1, 32'd1, 32'd0, 1'b1};
      tbl[8]  = '{2'b10, 2, 2'd0, 32'd0, 32'd0, 1'b0};
      tbl[9]  = '{2'b00, 2, 2'd0, 32'd0, 32'd2, 1'b1};
      tbl[10] = '{2'b00, 1, 2'd1, 32'd2, 32'd0, 1'b1};
      tbl[11] = '{2'b00, 2, 2'd0, 32'd0, 32'd0, 1'b0};
      tbl[12] = '{2'b01, 1, 2'd1, 32'd1, 32'd0, 1'b0};
      tbl[13] = '{2'b00, 2, 2'd0, 32'd0, 32'd1, 1'b1};
      tbl[14] = '{2'b01, 1, 2'd1, 32'd1, 32'd0, 1'b1};
      tbl[15] = '{2'b00, 2, 2'd3, 32'd0, 32'd0, 1'b1};
      tbl[16] = '{2'b01, 0, 2'd0, 32'd0, 32'd0, 1'b1};
      tbl[17] = '{2'b00, 2, 2'd3, 32'd0, 32'd1, 1'b1};
      tbl[18] = '{2'b00, 1, 2'd2, 32'd0, 32'd0, 1'b1};
      tbl[19] = '{2'b00, 2, 2'd0, 32'd0, 32'd1, 1'b0};
      tbl[20] = '{2'b00, 1, 2'd3, 32'd0, 32'd0, 1'b0};
      tbl[21] = '{2'b00, 2, 2'd3, 32'd0, 32'd0, 1'b0};
      tbl[22] = '{2'b00, 1, 2'd0, 32'd0, 32'd0, 1'b0};
      tbl[23] = '{2'b00, 2, 2'd0, 32'd0, 32'd1, 1'b0};
      tbl[24] = '{2'b00, 2, 2'd1, 32'd0, 32'd0, 1'b0};

      repeat (2) begin
         drive(1'b0, 2'b00, 0, 12'd0, 32'd0);
         edge_();
      end
      chk("pready", {31'd0, PREADY}, 32'd1);
      chk("pslverr", {31'd0, PSLVERR}, 32'd0);

      for (int i = 0; i < 25; i++) begin
         drive(1'b1, tbl[i].irq, tbl[i].op, ad(tbl[i].a), tbl[i].wd);
         chk($sformatf("tbl%0d prdata", i), PRDATA, tbl[i].rd);
         chk($sformatf("tbl%0d irq_o", i), {31'd0, irq_o}, {31'd0, tbl[i].io});
         edge_();
      end

      // saturation: first pulse sets pending, the other 299 are misses
      cycle(2'b00, 1, 2'd3, 32'd0);
      cycle(2'b00, 1, 2'd1, 32'd3);
      cycle(2'b00, 1, 2'd2, 32'd1);
      repeat (300) begin
         cycle(2'b01, 0, 2'd0, 32'd0);
         cycle(2'b00, 0, 2'd0, 32'd0);
      end
      rd_exp("sat status", 2'b00, 2'd0, 32'd1);
      rd_exp("sat miss", 2'b00, 2'd3, 32'h0000_00ff);
      cycle(2'b00, 1, 2'd3, 32'd0);
      rd_exp("sat miss clr", 2'b00, 2'd3, 32'd0);

      // level input held high captures once
      cycle(2'b00, 1, 2'd1, 32'd3);
      repeat (10) cycle(2'b10, 0, 2'd0, 32'd0);
      rd_exp("level status", 2'b10, 2'd0, 32'd2);
      cycle(2'b10, 1, 2'd1, 32'd2);
      rd_exp("level cleared", 2'b10, 2'd0, 32'd0);
      rd_exp("level miss", 2'b10, 2'd3, 32'd0);
      cycle(2'b00, 0, 2'd0, 32'd0);

      // reset mid-operation
      cycle(2'b00, 1, 2'd2, 32'd3);
      repeat (6) begin
         cycle(2'b11, 0, 2'd0, 32'd0);
         cycle(2'b00, 0, 2'd0, 32'd0);
      end
      rd_exp("pre-rst status", 2'b00, 2'd0, 32'd3);
      rd_exp("pre-rst miss", 2'b00, 2'd3, 32'h0000_0505);
      drive(1'b0, 2'b00, 2, ad(2'd0), 32'd0);
      chk("rst between edges status", PRDATA, 32'd3);
      chk("rst between edges irq_o", {31'd0, irq_o}, 32'd1);
      edge_();
      drive(1'b1, 2'b00, 2, ad(2'd0), 32'd0);
      chk("post-rst status", PRDATA, 32'd0);
      chk("post-rst irq_o", {31'd0, irq_o}, 32'd0);
      edge_();
      rd_exp("post-rst mask", 2'b00, 2'd2, 32'd0);
      rd_exp("post-rst miss", 2'b00, 2'd3, 32'd0);
      rd_exp("post-rst irq high first", 2'b11, 2'd0, 32'd0);
      rd_exp("first cycle event", 2'b11, 2'd0, 32'd3);

      // random traffic against the model
      repeat (3000) begin
         logic rst_n;
         logic [1:0] irq;
         logic [11:0] addr;
         logic [31:0] wd;
         int op;
         rst_n = $urandom_range(0, 199) != 0;
         irq = 2'($urandom);
         op = $urandom_range(0, 2);
         addr = 12'($urandom);
         wd = $urandom;
         drive(rst_n, irq, op, addr, wd);
         chk("rand irq_o", {31'd0, irq_o}, {31'd0, m_irq()});
         chk("rand prdata", PRDATA, op == 2 ? m_rd(addr[3:2]) : 32'd0);
         edge_();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
